// File: rtl/mc_control_fsm.sv
// Multicycle MIPS control unit: sequences each instruction through its states,
// drives ALU/datapath controls from a one-hot latched opcode, counts retired instructions.
module mc_control_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic             iord,
  output logic             memwrite,
  output logic             irwrite,
  output logic             regdst,
  output logic             memtoreg,
  output logic             regwrite,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic             extop,
  output logic [2:0]       aluop,
  output logic [1:0]       pcsrc,
  output logic             pcen,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_RTEXE, S_RTWB, S_IEXE, S_IWB, S_BRANCH, S_JUMP
  } state_t;

  typedef struct packed {
    logic lw, sw, beq, j, addi, ori, lui, add, sub, or_, slt;
  } instr_t;

  typedef struct packed {
    logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb;
    logic       extop;
    logic [2:0] aluop;
    logic [1:0] pcsrc;
    logic       pcwrite, branch;
  } ctrl_t;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_LUI = 3'b000;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  instr_t           r_instr;
  ctrl_t            r_ctrl;
  logic [CNT_W-1:0] r_instret;

  state_t w_next;
  instr_t w_next_instr;
  instr_t w_dec;
  logic   w_legal;
  logic   w_retire;
  ctrl_t  w_out;

  // Control word for a state; everything not named for a state stays 0.
  function automatic ctrl_t ctrl_for(input state_t s, input instr_t d);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.alusrcb = 2'b01;
        c.aluop   = ALU_ADD;
        c.irwrite = 1'b1;
        c.pcwrite = 1'b1;
      end
      S_DECODE: begin
        c.alusrcb = 2'b11;
        c.aluop   = ALU_ADD;
      end
      S_MEMADR: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
        c.aluop   = ALU_ADD;
      end
      S_MEMREAD: c.iord = 1'b1;
      S_MEMWB: begin
        c.memtoreg = 1'b1;
        c.regwrite = 1'b1;
      end
      S_MEMWRITE: begin
        c.iord     = 1'b1;
        c.memwrite = 1'b1;
      end
      S_RTEXE: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b00;
        if (d.sub)      c.aluop = ALU_SUB;
        else if (d.or_) c.aluop = ALU_OR;
        else if (d.slt) c.aluop = ALU_SLT;
        else            c.aluop = ALU_ADD;
      end
      S_RTWB: begin
        c.regdst   = 1'b1;
        c.regwrite = 1'b1;
      end
      S_IEXE: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
        if (d.ori) begin
          c.aluop = ALU_OR;
          c.extop = 1'b1;
        end else if (d.lui) begin
          c.aluop = ALU_LUI;
          c.extop = 1'b1;
        end else begin
          c.aluop = ALU_ADD;
        end
      end
      S_IWB: c.regwrite = 1'b1;
      S_BRANCH: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b00;
        c.aluop   = ALU_SUB;
        c.pcsrc   = 2'b01;
        c.branch  = d.beq;
      end
      S_JUMP: begin
        c.pcsrc   = 2'b10;
        c.pcwrite = d.j;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    w_dec     = '0;
    w_dec.lw  = (op == 6'b100011);
    w_dec.sw  = (op == 6'b101011);
    w_dec.beq = (op == 6'b000100);
    w_dec.j   = (op == 6'b000010);
    w_dec.addi = (op == 6'b001000);
    w_dec.ori = (op == 6'b001101);
    w_dec.lui = (op == 6'b001111);
    if (op == 6'b000000) begin
      w_dec.add = (funct == 6'b100000);
      w_dec.sub = (funct == 6'b100010);
      w_dec.or_ = (funct == 6'b100101);
      w_dec.slt = (funct == 6'b101010);
    end
    w_legal = |w_dec;
  end

  // op/funct only matter in DECODE; later states steer from the latch.
  always_comb begin
    w_next       = r_state;
    w_next_instr = r_instr;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        w_next_instr = w_dec;
        if (w_dec.lw || w_dec.sw)                             w_next = S_MEMADR;
        else if (w_dec.add || w_dec.sub || w_dec.or_ || w_dec.slt) w_next = S_RTEXE;
        else if (w_dec.beq)                                   w_next = S_BRANCH;
        else if (w_dec.addi || w_dec.ori || w_dec.lui)        w_next = S_IEXE;
        else if (w_dec.j)                                     w_next = S_JUMP;
        else                                                  w_next = S_FETCH;
      end
      S_MEMADR:  w_next = r_instr.lw ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: w_next = S_MEMWB;
      S_RTEXE:   w_next = S_RTWB;
      S_IEXE:    w_next = S_IWB;
      default:   w_next = S_FETCH;
    endcase
  end

  assign w_retire = (r_state == S_MEMWB) || (r_state == S_MEMWRITE) ||
                    (r_state == S_RTWB)  || (r_state == S_IWB) ||
                    (r_state == S_BRANCH) || (r_state == S_JUMP);

  // Outputs are registered from the decode of the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_instr   <= '0;
      r_ctrl    <= ctrl_for(S_FETCH, '0);
      r_instret <= '0;
    end else begin
      r_state <= w_next;
      r_instr <= w_next_instr;
      r_ctrl  <= ctrl_for(w_next, w_next_instr);
      if (w_retire) r_instret <= r_instret + CNT_ONE;
    end
  end

  // During reset selects show FETCH values while every enable is held low.
  always_comb begin
    w_out = r_ctrl;
    if (rst) begin
      w_out         = ctrl_for(S_FETCH, '0);
      w_out.irwrite = 1'b0;
      w_out.pcwrite = 1'b0;
    end
  end

  assign iord     = w_out.iord;
  assign memwrite = w_out.memwrite;
  assign irwrite  = w_out.irwrite;
  assign regdst   = w_out.regdst;
  assign memtoreg = w_out.memtoreg;
  assign regwrite = w_out.regwrite;
  assign alusrca  = w_out.alusrca;
  assign alusrcb  = w_out.alusrcb;
  assign extop    = w_out.extop;
  assign aluop    = w_out.aluop;
  assign pcsrc    = w_out.pcsrc;
  assign pcen     = w_out.pcwrite | (w_out.branch & zero);
  assign illegal  = ~rst & (r_state == S_DECODE) & ~w_legal;
  assign instret  = r_instret;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Cycle-accurate bench for mc_control_fsm: an independent state/output table
// predicts every cycle's controls and instret (CNT_W=4 so the counter wraps).
module tb_mc_control_fsm;

  localparam int CNT_W = 4;
  localparam int W     = 17 + CNT_W;

  localparam int T_FETCH = 0, T_DECODE = 1, T_MEMADR = 2, T_MEMREAD = 3, T_MEMWB = 4;
  localparam int T_MEMWRITE = 5, T_RTEXE = 6, T_RTWB = 7, T_IEXE = 8, T_IWB = 9;
  localparam int T_BRANCH = 10, T_JUMP = 11, T_RESET = 12;

  logic             clk = 1'b0;
  logic             rst;
  logic [5:0]       op, funct;
  logic             zero;
  logic             iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0]       alusrcb;
  logic             extop;
  logic [2:0]       aluop;
  logic [1:0]       pcsrc;
  logic             pcen, illegal;
  logic [CNT_W-1:0] instret;

  logic [W-1:0]     exp_q[$];
  logic [CNT_W-1:0] m_instret;
  int               n_checks = 0;
  int               n_pass   = 0;

  mc_control_fsm #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
    .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
    .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
    .extop(extop), .aluop(aluop), .pcsrc(pcsrc), .pcen(pcen), .illegal(illegal),
    .instret(instret)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Expected {iord,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca,alusrcb,extop,aluop,pcsrc,pcen,illegal}.
  function automatic logic [16:0] ev(input int st, input logic [5:0] o, input logic [5:0] f,
                                     input logic z, input logic ill);
    logic e_iord, e_mw, e_ir, e_rd, e_m2r, e_rw, e_sa, e_ext, e_pcen, e_ill;
    logic [1:0] e_sb, e_pcs;
    logic [2:0] e_alu;
    {e_iord, e_mw, e_ir, e_rd, e_m2r, e_rw, e_sa, e_ext, e_pcen, e_ill} = '0;
    e_sb = 2'b00; e_pcs = 2'b00; e_alu = 3'b000;
    case (st)
      T_FETCH:    begin e_sb = 2'b01; e_alu = 3'b010; e_ir = 1'b1; e_pcen = 1'b1; end
      T_DECODE:   begin e_sb = 2'b11; e_alu = 3'b010; e_ill = ill; end
      T_MEMADR:   begin e_sa = 1'b1; e_sb = 2'b10; e_alu = 3'b010; end
      T_MEMREAD:  e_iord = 1'b1;
      T_MEMWB:    begin e_m2r = 1'b1; e_rw = 1'b1; end
      T_MEMWRITE: begin e_iord = 1'b1; e_mw = 1'b1; end
      T_RTEXE: begin
        e_sa = 1'b1;
        case (f)
          6'b100000: e_alu = 3'b010;
          6'b100010: e_alu = 3'b110;
          6'b100101: e_alu = 3'b001;
          default:   e_alu = 3'b111;
        endcase
      end
      T_RTWB:     begin e_rd = 1'b1; e_rw = 1'b1; end
      T_IEXE: begin
        e_sa = 1'b1; e_sb = 2'b10;
        case (o)
          6'b001101: begin e_alu = 3'b001; e_ext = 1'b1; end
          6'b001111: begin e_alu = 3'b000; e_ext = 1'b1; end
          default:   e_alu = 3'b010;
        endcase
      end
      T_IWB:      e_rw = 1'b1;
      T_BRANCH:   begin e_sa = 1'b1; e_alu = 3'b110; e_pcs = 2'b01; e_pcen = z; end
      T_JUMP:     begin e_pcs = 2'b10; e_pcen = 1'b1; end
      default:    begin e_sb = 2'b01; e_alu = 3'b010; end
    endcase
    return {e_iord, e_mw, e_ir, e_rd, e_m2r, e_rw, e_sa, e_sb, e_ext, e_alu, e_pcs, e_pcen, e_ill};
  endfunction

  // One cycle: drive inputs, queue the prediction, compare mid-cycle, advance the model.
  task automatic step(input string tag, input int st, input logic [5:0] m_op, input logic [5:0] m_fn,
                      input logic z, input logic ill, input logic [5:0] d_op, input logic [5:0] d_fn,
                      input logic d_rst, input logic retire);
    logic [W-1:0] got;
    rst = d_rst; op = d_op; funct = d_fn; zero = z;
    exp_q.push_back({ev(st, m_op, m_fn, z, ill), m_instret});
    @(negedge clk);
    got = {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, alusrcb,
           extop, aluop, pcsrc, pcen, illegal, instret};
    check($sformatf("%s/st%0d", tag, st), got, exp_q.pop_front());
    @(posedge clk);
    #1;
    if (d_rst) m_instret = '0;
    else if (retire) m_instret = m_instret + 1'b1;
  endtask

  task automatic run_instr(input string tag, input logic [5:0] i_op, input logic [5:0] i_fn,
                           input logic i_zero);
    int seq[$];
    logic ill;
    logic rfn;
    rfn = (i_fn == 6'b100000) || (i_fn == 6'b100010) || (i_fn == 6'b100101) || (i_fn == 6'b101010);
    ill = 1'b0;
    seq = '{T_FETCH, T_DECODE};
    case (i_op)
      6'b100011: begin seq.push_back(T_MEMADR); seq.push_back(T_MEMREAD); seq.push_back(T_MEMWB); end
      6'b101011: begin seq.push_back(T_MEMADR); seq.push_back(T_MEMWRITE); end
      6'b000100: seq.push_back(T_BRANCH);
      6'b000010: seq.push_back(T_JUMP);
      6'b001000, 6'b001101, 6'b001111: begin seq.push_back(T_IEXE); seq.push_back(T_IWB); end
      6'b000000: if (rfn) begin seq.push_back(T_RTEXE); seq.push_back(T_RTWB); end else ill = 1'b1;
      default: ill = 1'b1;
    endcase
    for (int k = 0; k < seq.size(); k++) begin
      logic [5:0] d_op, d_fn;
      logic z;
      d_op = (k < 2) ? i_op : 6'($urandom_range(0, 63));
      d_fn = (k < 2) ? i_fn : 6'($urandom_range(0, 63));
      z = (seq[k] == T_BRANCH) ? i_zero : 1'($urandom_range(0, 1));
      step(tag, seq[k], i_op, i_fn, z, ill, d_op, d_fn, 1'b0,
           (k == seq.size() - 1) && !ill);
    end
  endtask

  logic [11:0] tbl[12];

  initial begin
    rst = 1'b1; op = 6'b0; funct = 6'b0; zero = 1'b0;
    m_instret = '0;
    tbl = '{{6'b100011, 6'd0}, {6'b101011, 6'd0}, {6'b000100, 6'd0}, {6'b000010, 6'd0},
            {6'b001000, 6'd0}, {6'b001101, 6'd0}, {6'b001111, 6'd0}, {6'b000000, 6'b100000},
            {6'b000000, 6'b100010}, {6'b000000, 6'b100101}, {6'b000000, 6'b101010},
            {6'b110111, 6'b000000}};
    @(posedge clk);
    #1;
    step("reset", T_RESET, 6'd0, 6'd0, 1'b1, 1'b0, 6'd0, 6'd0, 1'b1, 1'b0);
    step("reset", T_RESET, 6'd0, 6'd0, 1'b1, 1'b0, 6'd0, 6'd0, 1'b1, 1'b0);

    run_instr("lw", 6'b100011, 6'd0, 1'b0);
    run_instr("add", 6'b000000, 6'b100000, 1'b0);
    run_instr("sub", 6'b000000, 6'b100010, 1'b1);
    run_instr("or", 6'b000000, 6'b100101, 1'b0);
    run_instr("slt", 6'b000000, 6'b101010, 1'b1);
    run_instr("ori", 6'b001101, 6'd0, 1'b0);
    run_instr("lui", 6'b001111, 6'd0, 1'b0);
    run_instr("addi", 6'b001000, 6'd0, 1'b1);
    run_instr("beq_t", 6'b000100, 6'd0, 1'b1);
    run_instr("beq_nt", 6'b000100, 6'd0, 1'b0);
    run_instr("j", 6'b000010, 6'd0, 1'b0);
    run_instr("sw", 6'b101011, 6'd0, 1'b1);
    run_instr("ill_op", 6'b111111, 6'd0, 1'b0);
    run_instr("ill_fn", 6'b000000, 6'b000000, 1'b0);

    // Abort a lw in MEMREAD with two reset cycles: no writeback, no retire.
    step("abort", T_FETCH, 6'b100011, 6'd0, 1'b0, 1'b0, 6'b100011, 6'd0, 1'b0, 1'b0);
    step("abort", T_DECODE, 6'b100011, 6'd0, 1'b0, 1'b0, 6'b100011, 6'd0, 1'b0, 1'b0);
    step("abort", T_MEMADR, 6'b100011, 6'd0, 1'b0, 1'b0, 6'b100011, 6'd0, 1'b0, 1'b0);
    step("abort_rst", T_RESET, 6'd0, 6'd0, 1'b1, 1'b0, 6'b100011, 6'd0, 1'b1, 1'b0);
    step("abort_rst", T_RESET, 6'd0, 6'd0, 1'b0, 1'b0, 6'b100011, 6'd0, 1'b1, 1'b0);
    run_instr("post_rst_or", 6'b000000, 6'b100101, 1'b0);

    // Enough random retirements to wrap the 4-bit counter more than once.
    for (int n = 0; n < 40; n++) begin
      int idx;
      idx = $urandom_range(0, 11);
      run_instr($sformatf("rnd%0d", n), tbl[idx][11:6], tbl[idx][5:0], 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
